// File: rtl/tdd_ng_channel_monitor_if.sv
// tdd_ng_channel_monitor_if: TDD controller outputs seen by the channel monitor, plus its measurement readback
interface tdd_ng_channel_monitor_if #(
  parameter int CHANNEL_COUNT = 8,
  parameter int COUNTER_WIDTH = 32
);
  logic                     enable;
  logic [4:0]               ch_sel;
  logic                     tdd_sync;
  logic [CHANNEL_COUNT-1:0] tdd_channel;
`ifdef TDD_MON_POLARITY_EN
  logic [CHANNEL_COUNT-1:0] ch_polarity;
`endif
  logic [1:0]               state;
  logic                     meas_valid;
  logic [COUNTER_WIDTH-1:0] frame_length;
  logic [COUNTER_WIDTH-1:0] ch_on_offset;
  logic [COUNTER_WIDTH-1:0] ch_off_offset;
  logic                     ch_on_seen;
  logic                     ch_off_seen;
  logic [31:0]              frame_count;
  logic                     err_length;
  logic                     err_timeout;
  logic                     err_glitch;
`ifdef TDD_MON_POLARITY_EN
  modport master (output enable, ch_sel, tdd_sync, tdd_channel, ch_polarity,
                  input state, meas_valid, frame_length, ch_on_offset, ch_off_offset,
                  ch_on_seen, ch_off_seen, frame_count, err_length, err_timeout, err_glitch);
  modport slave (input enable, ch_sel, tdd_sync, tdd_channel, ch_polarity,
                 output state, meas_valid, frame_length, ch_on_offset, ch_off_offset,
                 ch_on_seen, ch_off_seen, frame_count, err_length, err_timeout, err_glitch);
`else
  modport master (output enable, ch_sel, tdd_sync, tdd_channel,
                  input state, meas_valid, frame_length, ch_on_offset, ch_off_offset,
                  ch_on_seen, ch_off_seen, frame_count, err_length, err_timeout, err_glitch);
  modport slave (input enable, ch_sel, tdd_sync, tdd_channel,
                 output state, meas_valid, frame_length, ch_on_offset, ch_off_offset,
                 ch_on_seen, ch_off_seen, frame_count, err_length, err_timeout, err_glitch);
`endif
endinterface

// File: rtl/tdd_ng_channel_monitor.sv
// tdd_ng_channel_monitor: measures frame length and one channel's on/off offsets per frame; TDD_MON_POLARITY_EN adds per-channel inversion
module tdd_ng_channel_monitor #(
  parameter int CHANNEL_COUNT = 8,
  parameter int COUNTER_WIDTH = 32
) (
  input logic clk,
  input logic rst,
  tdd_ng_channel_monitor_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, RUNNING = 2'd2} state_t;
  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;
  state_t                   state_q;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d, on_off_q, on_off_d, off_off_q, off_off_d, offset;
  logic [COUNTER_WIDTH-1:0] len_q, on_out_q, off_out_q;
  logic                     on_seen_q, on_seen_d, off_seen_q, off_seen_d;
  logic                     on_out_seen_q, off_out_seen_q, mv_q, el_q, et_q, eg_q;
  logic [31:0]              fc_q, fc_d;
  logic [4:0]               sel_q, sel_in, sel_cur;
  logic [CHANNEL_COUNT-1:0] chan, prev_q;
  logic                     start, close, sync_any, active, cur_bit, prev_bit, rise, fall, glitch, timeout;
`ifdef TDD_MON_POLARITY_EN
  assign chan = bus.tdd_channel ^ bus.ch_polarity;
`else
  assign chan = bus.tdd_channel;
`endif
  // Edge detection on the selected channel and next values of the counter and per-frame shadows
  always_comb begin
    sel_in = (int'(bus.ch_sel) < CHANNEL_COUNT) ? bus.ch_sel : 5'd0;
    start = state_q == ARMED && bus.tdd_sync;
    close = state_q == RUNNING && bus.tdd_sync;
    sync_any = start || close;
    active = start || state_q == RUNNING;
    sel_cur = sync_any ? sel_in : sel_q;
    cur_bit = |(chan & (CHANNEL_COUNT'(1) << sel_cur));
    prev_bit = !start && |(prev_q & (CHANNEL_COUNT'(1) << sel_cur));
    rise = active && cur_bit && !prev_bit;
    fall = active && !cur_bit && prev_bit;
    offset = sync_any ? '0 : cnt_q;
    cnt_d = sync_any ? COUNTER_WIDTH'(1) : (cnt_q == CNT_MAX ? cnt_q : cnt_q + COUNTER_WIDTH'(1));
    on_seen_d = sync_any ? rise : on_seen_q || rise;
    off_seen_d = sync_any ? fall : off_seen_q || fall;
    on_off_d = sync_any ? '0 : (rise && !on_seen_q) ? offset : on_off_q;
    off_off_d = sync_any ? '0 : (fall && !off_seen_q) ? offset : off_off_q;
    glitch = !sync_any && ((rise && on_seen_q) || (fall && off_seen_q));
    timeout = state_q == RUNNING && !bus.tdd_sync && cnt_q == CNT_MAX;
    fc_d = (&fc_q) ? fc_q : fc_q + 32'd1;
  end
  // Frame FSM, shadows, publish on the closing sync and sticky errors; disable behaves like reset
  always_ff @(posedge clk) begin
    if (rst || !bus.enable) begin
      state_q <= IDLE;
      cnt_q <= '0;
      on_off_q <= '0;
      off_off_q <= '0;
      on_seen_q <= 1'b0;
      off_seen_q <= 1'b0;
      sel_q <= '0;
      prev_q <= '0;
      len_q <= '0;
      on_out_q <= '0;
      off_out_q <= '0;
      on_out_seen_q <= 1'b0;
      off_out_seen_q <= 1'b0;
      fc_q <= '0;
      mv_q <= 1'b0;
      el_q <= 1'b0;
      et_q <= 1'b0;
      eg_q <= 1'b0;
    end else begin
      prev_q <= chan;
      mv_q <= close;
      if (state_q == IDLE) state_q <= ARMED;
      if (start) state_q <= RUNNING;
      if (sync_any) sel_q <= sel_in;
      if (active) begin
        cnt_q <= cnt_d;
        on_off_q <= on_off_d;
        off_off_q <= off_off_d;
        on_seen_q <= on_seen_d;
        off_seen_q <= off_seen_d;
      end
      if (close) begin
        len_q <= cnt_q;
        on_out_q <= on_off_q;
        off_out_q <= off_off_q;
        on_out_seen_q <= on_seen_q;
        off_out_seen_q <= off_seen_q;
        fc_q <= fc_d;
        el_q <= el_q || (fc_q != '0 && cnt_q != len_q);
      end
      et_q <= et_q || timeout;
      eg_q <= eg_q || glitch;
    end
  end
  assign bus.state = state_q;
  assign bus.meas_valid = mv_q;
  assign bus.frame_length = len_q;
  assign bus.ch_on_offset = on_out_q;
  assign bus.ch_off_offset = off_out_q;
  assign bus.ch_on_seen = on_out_seen_q;
  assign bus.ch_off_seen = off_out_seen_q;
  assign bus.frame_count = fc_q;
  assign bus.err_length = el_q;
  assign bus.err_timeout = et_q;
  assign bus.err_glitch = eg_q;
endmodule

// File: tb/tb_tdd_ng_channel_monitor.sv
// tb_tdd_ng_channel_monitor: vector table, corner sequences and randomized run against a frame-trace model
module tb_tdd_ng_channel_monitor;
  localparam int CC = 8;
  localparam int W = 32;
  localparam longint MAXV = (64'd1 << W) - 1;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, sync = 1'b0;
  logic [4:0] sel = '0;
  logic [CC-1:0] ch = '0, pol = '0;
  int total = 0, bad = 0;
  bit chk_model = 1'b0;
  always #5 clk = ~clk;
  tdd_ng_channel_monitor_if #(.CHANNEL_COUNT(CC), .COUNTER_WIDTH(W)) b32 ();
  tdd_ng_channel_monitor_if #(.CHANNEL_COUNT(CC), .COUNTER_WIDTH(8)) b8 ();
  assign b32.enable = en;
  assign b32.ch_sel = sel;
  assign b32.tdd_sync = sync;
  assign b32.tdd_channel = ch;
  assign b8.enable = en;
  assign b8.ch_sel = sel;
  assign b8.tdd_sync = sync;
  assign b8.tdd_channel = ch;
`ifdef TDD_MON_POLARITY_EN
  assign b32.ch_polarity = pol;
  assign b8.ch_polarity = pol;
`endif
  tdd_ng_channel_monitor #(.CHANNEL_COUNT(CC), .COUNTER_WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(b32));
  tdd_ng_channel_monitor #(.CHANNEL_COUNT(CC), .COUNTER_WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));

  typedef struct {
    int len; int s; int a; int b;
    longint e_len; longint e_on; longint e_off; bit e_ons; bit e_offs; bit e_el;
  } vec_t;
  vec_t tv[6];

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_zero(input string t);
    chk({t, "_state"}, b32.state, 0);
    chk({t, "_mv"}, b32.meas_valid, 0);
    chk({t, "_len"}, b32.frame_length, 0);
    chk({t, "_on"}, b32.ch_on_offset, 0);
    chk({t, "_off"}, b32.ch_off_offset, 0);
    chk({t, "_ons"}, b32.ch_on_seen, 0);
    chk({t, "_offs"}, b32.ch_off_seen, 0);
    chk({t, "_fc"}, b32.frame_count, 0);
    chk({t, "_el"}, b32.err_length, 0);
    chk({t, "_et"}, b32.err_timeout, 0);
    chk({t, "_eg"}, b32.err_glitch, 0);
  endtask

  task automatic check_vec(input int k);
    chk($sformatf("tv%0d_state", k), b32.state, 2);
    chk($sformatf("tv%0d_mv", k), b32.meas_valid, 1);
    chk($sformatf("tv%0d_len", k), b32.frame_length, tv[k].e_len);
    chk($sformatf("tv%0d_on", k), b32.ch_on_offset, tv[k].e_on);
    chk($sformatf("tv%0d_off", k), b32.ch_off_offset, tv[k].e_off);
    chk($sformatf("tv%0d_ons", k), b32.ch_on_seen, tv[k].e_ons);
    chk($sformatf("tv%0d_offs", k), b32.ch_off_seen, tv[k].e_offs);
    chk($sformatf("tv%0d_fc", k), b32.frame_count, k + 1);
    chk($sformatf("tv%0d_el", k), b32.err_length, tv[k].e_el);
    chk($sformatf("tv%0d_eg", k), b32.err_glitch, 0);
  endtask

  // one frame: sync at offset 0, selected channel active in [a,b) and [a2,b2); ck>=0 checks the frame it closes
  task automatic run_frame(input int len, input int s, input int a, input int b, input int a2, input int b2, input int ck);
    int bi;
    bi = (s < CC) ? s : 0;
    sel = 5'(s);
    for (int o = 0; o < len; o++) begin
      sync = (o == 0);
      ch = pol;
      ch[bi] = ((o >= a && o < b) || (o >= a2 && o < b2)) ^ pol[bi];
      tick();
      if (o == 0 && ck >= 0) check_vec(ck);
      if (o == 1) chk("mv_one_cycle", b32.meas_valid, 0);
    end
    sync = 1'b0;
  endtask

  task automatic close_frame();
    sync = 1'b1;
    ch = pol;
    tick();
    sync = 1'b0;
  endtask

  // reference model: keeps the selected channel's samples of the current frame and derives results from them
  int m_st = 0, m_sel = 0;
  bit m_q[$];
  bit m_prev0 = 1'b0;
  logic [CC-1:0] m_prev = '0;
  bit e_mv = 0, e_ons = 0, e_offs = 0, e_el = 0, e_et = 0, e_eg = 0;
  longint e_len = 0, e_on = 0, e_off = 0, e_fc = 0;

  function automatic int eff(input logic [4:0] s);
    return (int'(s) < CC) ? int'(s) : 0;
  endfunction

  function automatic longint sat(input longint v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  task automatic scan(output int fr, output int ff, output int nr, output int nf);
    bit p;
    fr = -1; ff = -1; nr = 0; nf = 0;
    for (int i = 0; i < m_q.size(); i++) begin
      p = (i == 0) ? m_prev0 : m_q[i-1];
      if (m_q[i] && !p) begin nr++; if (fr < 0) fr = i; end
      if (!m_q[i] && p) begin nf++; if (ff < 0) ff = i; end
    end
  endtask

  always @(posedge clk) begin : model
    logic [CC-1:0] x;
    int fr, ff, nr, nf;
    longint len;
    x = ch ^ pol;
    e_mv = 1'b0;
    if (rst || !en) begin
      m_st = 0; m_q.delete();
      e_ons = 0; e_offs = 0; e_el = 0; e_et = 0; e_eg = 0;
      e_len = 0; e_on = 0; e_off = 0; e_fc = 0;
    end else if (m_st == 0) m_st = 1;
    else if (m_st == 1) begin
      if (sync) begin
        m_st = 2; m_prev0 = 1'b0; m_sel = eff(sel); m_q.delete(); m_q.push_back(x[m_sel]);
      end
    end else begin
      if (sync) begin
        scan(fr, ff, nr, nf);
        len = sat(m_q.size());
        if (e_fc != 0 && len != e_len) e_el = 1'b1;
        e_len = len;
        e_ons = fr >= 0; e_on = (fr >= 0) ? sat(fr) : 0;
        e_offs = ff >= 0; e_off = (ff >= 0) ? sat(ff) : 0;
        e_fc = (e_fc == 64'hFFFFFFFF) ? e_fc : e_fc + 1;
        e_mv = 1'b1;
        m_sel = eff(sel); m_prev0 = m_prev[m_sel]; m_q.delete(); m_q.push_back(x[m_sel]);
      end else begin
        if (m_q.size() >= MAXV) e_et = 1'b1;
        m_q.push_back(x[m_sel]);
      end
      scan(fr, ff, nr, nf);
      if (nr > 1 || nf > 1) e_eg = 1'b1;
    end
    m_prev = x;
  end

  always @(negedge clk) if (chk_model) begin
    chk("rnd_state", b32.state, m_st);
    chk("rnd_mv", b32.meas_valid, e_mv);
    chk("rnd_len", b32.frame_length, e_len);
    chk("rnd_on", b32.ch_on_offset, e_on);
    chk("rnd_off", b32.ch_off_offset, e_off);
    chk("rnd_ons", b32.ch_on_seen, e_ons);
    chk("rnd_offs", b32.ch_off_seen, e_offs);
    chk("rnd_fc", b32.frame_count, e_fc);
    chk("rnd_el", b32.err_length, e_el);
    chk("rnd_et", b32.err_timeout, e_et);
    chk("rnd_eg", b32.err_glitch, e_eg);
  end

  initial begin
    tv[0] = '{100, 2, 10, 40, 100, 10, 40, 1, 1, 0};
    tv[1] = '{100, 2, 0, 0, 100, 0, 0, 0, 0, 0};
    tv[2] = '{50, 5, 0, 20, 50, 0, 20, 1, 1, 1};
    tv[3] = '{30, 9, 29, 30, 30, 29, 0, 1, 0, 1};
    tv[4] = '{20, 0, 0, 5, 20, 0, 5, 0, 1, 1};
    tv[5] = '{1, 1, 0, 1, 1, 0, 0, 1, 0, 1};
    tick(); tick();
    check_zero("rst");
    rst = 1'b0;
    en = 1'b1;
    tick();
    chk("armed_state", b32.state, 1);
    for (int k = 0; k < 6; k++) run_frame(tv[k].len, tv[k].s, tv[k].a, tv[k].b, 0, 0, k - 1);
    run_frame(1, 1, 0, 0, 0, 0, 5);
    en = 1'b0;
    tick();
    check_zero("disable");
    en = 1'b1;
    tick();
    run_frame(40, 2, 5, 10, 20, 25, -1);
    close_frame();
    chk("glitch_mv", b32.meas_valid, 1);
    chk("glitch_len", b32.frame_length, 40);
    chk("glitch_on", b32.ch_on_offset, 5);
    chk("glitch_off", b32.ch_off_offset, 10);
    chk("glitch_ons", b32.ch_on_seen, 1);
    chk("glitch_eg", b32.err_glitch, 1);
    chk("glitch_fc", b32.frame_count, 1);
    en = 1'b0; tick(); en = 1'b1; tick();
    run_frame(10, 2, 0, 5, 0, 0, -1);
    close_frame();
    chk("coinc_on", b32.ch_on_offset, 0);
    chk("coinc_ons", b32.ch_on_seen, 1);
    chk("coinc_off", b32.ch_off_offset, 5);
    chk("coinc_eg", b32.err_glitch, 0);
    ch[2] = 1'b1; tick(); tick();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abandon_mv", b32.meas_valid, 0);
    end
    check_zero("abandon");
    en = 1'b1; ch = '0; tick();
    close_frame();
    for (int i = 0; i < 200; i++) tick();
    chk("to_early", b8.err_timeout, 0);
    for (int i = 0; i < 100; i++) tick();
    chk("to_set8", b8.err_timeout, 1);
    chk("to_clear32", b32.err_timeout, 0);
    close_frame();
    chk("to_len8", b8.frame_length, 255);
    chk("to_mv8", b8.meas_valid, 1);
    chk("to_len32", b32.frame_length, 301);
`ifdef TDD_MON_POLARITY_EN
    en = 1'b0; pol = 8'h04; ch = pol; tick(); en = 1'b1; tick();
    run_frame(100, 2, 10, 40, 0, 0, -1);
    close_frame();
    chk("pol_on", b32.ch_on_offset, 10);
    chk("pol_off", b32.ch_off_offset, 40);
    chk("pol_ons", b32.ch_on_seen, 1);
    chk("pol_offs", b32.ch_off_seen, 1);
    pol = '0;
`endif
    rst = 1'b1; ch = '0; tick(); rst = 1'b0;
    chk_model = 1'b1;
    for (int f = 0; f < 60; f++) begin
      int len;
      len = $urandom_range(1, 40);
      sel = 5'($urandom_range(0, 9));
      for (int o = 0; o < len; o++) begin
        int k;
        sync = (o == 0);
        k = $urandom_range(0, 7);
        if ($urandom_range(0, 5) == 0) ch[k] = ~ch[k];
        en = ($urandom_range(0, 149) != 0);
        tick();
      end
    end
    chk_model = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
